// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_if
// Brief    : Fetch-stage bundle: consumer control, ROM port and IR outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_if #(
    parameter int PC_W = 8,
    parameter int IW   = 16
);
    logic            stall;
    logic            jmp;
    logic [PC_W-1:0] jmp_target;
    logic [PC_W-1:0] rom_addr;
    logic [IW-1:0]   rom_data;
    logic [IW-1:0]   ir;
    logic [PC_W-1:0] ir_pc;
    logic            ir_valid;
    logic            halted;

    // master: the fetch stage itself
    modport master (
        input  stall, jmp, jmp_target, rom_data,
        output rom_addr, ir, ir_pc, ir_valid, halted
    );

    // slave: decode/control logic plus the program ROM
    modport slave (
        output stall, jmp, jmp_target, rom_data,
        input  rom_addr, ir, ir_pc, ir_valid, halted
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : PC owner and IR stage hiding the one-cycle synchronous ROM read.
//            Optional HALT opcode stop enabled by macro FETCH_HALT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int PC_W     = 8,
    parameter int IW       = 16,
    parameter int RESET_PC = 0
) (
    input  wire logic  clk,
    input  wire logic  rst,
    fetch_if.master    bus
);

    localparam logic [3:0] c_OP_HALT = 4'hF;

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_pend_pc;
    logic            r_pend;
    logic [IW-1:0]   r_ir;
    logic [PC_W-1:0] r_ir_pc;
    logic            r_ir_valid;
    logic            r_halted;
    logic            w_halt_hit;
    logic [PC_W-1:0] w_rom_addr;

`ifdef FETCH_HALT_EN
    assign w_halt_hit = r_pend && (bus.rom_data[IW-1:IW-4] == c_OP_HALT);
`else
    assign w_halt_hit = 1'b0;
`endif

    // Stall re-presents the in-flight address so the ROM keeps the same word.
    always_comb begin
        w_rom_addr = r_pc;
        if (bus.jmp) begin
            w_rom_addr = bus.jmp_target;
        end else if (bus.stall) begin
            w_rom_addr = r_pend_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= PC_W'(RESET_PC);
            r_pend_pc  <= '0;
            r_pend     <= 1'b0;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else if (r_halted) begin
            r_ir_valid <= 1'b0;
        end else if (bus.jmp) begin
            // In-flight word is dropped; ir_pc keeps the last presented address.
            r_pend_pc  <= bus.jmp_target;
            r_pend     <= 1'b1;
            r_pc       <= bus.jmp_target + 1'b1;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else if (!bus.stall) begin
            r_ir       <= bus.rom_data;
            r_ir_pc    <= r_pend_pc;
            r_ir_valid <= r_pend;
            r_pend_pc  <= r_pc;
            r_pend     <= 1'b1;
            r_pc       <= r_pc + 1'b1;
            if (w_halt_hit) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign bus.rom_addr = w_rom_addr;
    assign bus.ir       = r_ir;
    assign bus.ir_pc    = r_ir_pc;
    assign bus.ir_valid = r_ir_valid;
    assign bus.halted   = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Scoreboard bench for fetch_stage with an instruction-stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    typedef struct {
        logic        v;
        logic [15:0] ir;
        logic [7:0]  pc;
        logic        h;
        bit          chk_ir;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] rom [256];
    logic [15:0] rom_q;

    int checks   = 0;
    int failures = 0;

    exp_t q[$];
    exp_t last;
    logic [7:0] m_seq;
    int         m_bub;
    bit         m_halted;

    fetch_if #(.PC_W(8), .IW(16)) bus ();

    fetch_stage #(.PC_W(8), .IW(16), .RESET_PC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom[bus.rom_addr];
    assign bus.rom_data = rom_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the presented stream is ROM[seq], ROM[seq+1], ... with one bubble
    // after reset and after a jump; stalls replay the previous output.
    task automatic step(input logic s, input logic j, input logic [7:0] t);
        exp_t e;
        bus.stall      = s;
        bus.jmp        = j;
        bus.jmp_target = t;
        e = last;
        if (m_halted) begin
            e.v = 1'b0;
        end else if (j) begin
            e.v = 1'b0; e.ir = 16'h0; e.chk_ir = 1'b1;
            m_seq = t; m_bub = 0;
        end else if (s) begin
            e = last;
        end else if (m_bub > 0) begin
            m_bub--;
            e.v = 1'b0; e.chk_ir = 1'b0;
        end else begin
            e.v = 1'b1; e.ir = rom[m_seq]; e.pc = m_seq; e.chk_ir = 1'b1;
`ifdef FETCH_HALT_EN
            if (rom[m_seq][15:12] == 4'hF) begin
                m_halted = 1'b1;
                e.h = 1'b1;
            end
`endif
            m_seq = m_seq + 8'd1;
        end
        q.push_back(e);
        last = e;
        @(negedge clk);
    endtask

    task automatic reset_assert();
        @(posedge clk);
        #3;
        bus.stall = 1'b0;
        bus.jmp   = 1'b0;
        rst       = 1'b1;
        #1;
        chk("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        chk("rst_ir",       32'(bus.ir),       32'd0);
        chk("rst_ir_pc",    32'(bus.ir_pc),    32'd0);
        chk("rst_halted",   32'(bus.halted),   32'd0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst      = 1'b0;
        m_seq    = 8'd0;
        m_bub    = 1;
        m_halted = 1'b0;
        last     = '{v: 1'b0, ir: 16'h0, pc: 8'h0, h: 1'b0, chk_ir: 1'b1};
    endtask

    task automatic fill_seq();
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
    endtask

    // Monitor: one expected entry per stepped edge, checked just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ir_valid", 32'(bus.ir_valid), 32'(e.v));
                chk("ir_pc",    32'(bus.ir_pc),    32'(e.pc));
                chk("halted",   32'(bus.halted),   32'(e.h));
                if (e.chk_ir) chk("ir", 32'(bus.ir), 32'(e.ir));
            end
        end
    end

    initial begin
        bus.stall      = 1'b0;
        bus.jmp        = 1'b0;
        bus.jmp_target = 8'h0;
        fill_seq();

        // Sequential fetch across the 8'hFF -> 8'h00 wrap
        reset_assert();
        reset_release();
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 8'h0);

        // Stall for three cycles while ir_pc = 5
        reset_assert();
        reset_release();
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h0);

        // Jump to 8'h40 once ir_pc reaches 8'h10, then jump+stall to 8'h20
        reset_assert();
        reset_release();
        for (int i = 0; i < 18; i++) step(1'b0, 1'b0, 8'h0);
        step(1'b0, 1'b1, 8'h40);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h0);
        step(1'b1, 1'b1, 8'h20);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h0);

        // HALT opcode at address 3, jmp pulses afterwards, then async reset
        reset_assert();
        fill_seq();
        rom[3] = 16'hF000;
        reset_release();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 8'h30);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h0);
        reset_assert();
        reset_release();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h0);

        // Randomized ROM contents, stalls, jumps and a mid-stream reset
        reset_assert();
        for (int i = 0; i < 256; i++)
            rom[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        reset_release();
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (i == 700) begin
                reset_assert();
                reset_release();
            end
            step((r < 25) || (r >= 95), (r >= 88), 8'($urandom));
        end

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage placed directly upstream of the processor's decode/control logic. It owns the program counter, drives the synchronous program ROM address, and compensates for the ROM's one-cycle read latency. It presents one instruction per cycle in an instruction register with its address and a valid flag. It supports consumer-driven stall and jump; a jump costs one bubble cycle.

## Interface
Parameters:
- PC_W, 8, program counter and ROM address width
- IW, 16, instruction width; opcode is ir[IW-1:IW-4]
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold the fetch stage and the instruction register
- jmp  in  1  redirect fetch to jmp_target; sampled at the clock edge
- jmp_target  in  PC_W  jump destination address
- rom_addr  out  PC_W  address to the program ROM, which registers it on clk
- rom_data  in  IW  ROM word for the address registered at the previous edge
- ir  out  IW  current instruction
- ir_pc  out  PC_W  address of ir
- ir_valid  out  1  ir holds a real fetched instruction
- halted  out  1  fetch stopped by HALT (see Configuration)

## Operation
- Internal state:
  - pc: next address to fetch
  - pend_pc: address in flight in the ROM
  - pend: in-flight word is live
- Reset values: pc=RESET_PC, pend=0, pend_pc=0, ir=0 (NOP), ir_pc=0, ir_valid=0, halted=0.
- rom_addr is combinational, with this priority:
  - jmp=1 → jmp_target
  - otherwise stall=1 → pend_pc, so the in-flight word stays on rom_data
  - otherwise → pc
- Normal edge (no jmp, no stall, not halted):
  - ir←rom_data, ir_pc←pend_pc, ir_valid←pend
  - pend_pc←pc, pend←1, pc←pc+1
- Stall edge (jmp=0): every register holds, including ir, ir_pc and ir_valid.
- Jump edge (priority over stall):
  - pend_pc←jmp_target, pend←1, pc←jmp_target+1
  - ir←0, ir_valid←0; the in-flight word is discarded
  - ir_pc holds its value
- Arithmetic: pc increments modulo 2^PC_W (all-ones wraps to 0); jmp_target+1 wraps the same way.
- Halted state (macro only): every register freezes, including ir, ir_pc and pc. ir_valid=0. jmp and stall are ignored. Only rst exits this state.

## Timing
- Reset is asynchronous: outputs take their reset values immediately on rst rising, without a clock edge.
- After rst deasserts:
  - edge 1: pend=1, pend_pc=RESET_PC
  - edge 2: ir=ROM[RESET_PC], ir_valid=1
- Throughput: one instruction per cycle while stall=0.
- Jump latency: ir_valid=0 for exactly one cycle after the jump edge. The next edge loads ROM[jmp_target].
- Stall:
  - Zero-cycle effect on entry.
  - On release, the first edge loads the next sequential instruction.
  - No instruction is skipped or duplicated.
- jmp and stall asserted together: the jump is taken and the stall has no effect that cycle.
- Reset mid-stream (including mid-stall or while halted): the next instruction after release is ROM[RESET_PC], following the same two-edge sequence.

## Configuration
- FETCH_HALT_EN defined:
  - On a normal edge, if pend=1 and rom_data opcode is 4'hF, that word loads into ir with ir_valid=1.
  - On the same edge, halted←1 and the halted state is entered.
  - ir_valid drops to 0 on the following edge and stays 0.
- FETCH_HALT_EN undefined:
  - Opcode 4'hF is fetched as an ordinary instruction.
  - halted is tied to 0.

## Test plan
- Sequential fetch: ROM[i]=16'h1000+i, release reset → ir_valid=0 after edge 1; at edge 2 ir=16'h1000, ir_pc=0, ir_valid=1; then 16'h1001, 16'h1002 on consecutive edges.
- Wrap: run 258 cycles → ir_pc goes 8'hFF→8'h00, ir=ROM[0] follows ROM[255], ir_valid stays 1.
- Stall: assert stall for 3 cycles while ir_pc=5 → ir=ROM[5] holds for 3 cycles; the first edge after release gives ir_pc=6, with no gap or repeat.
- Jump: jmp=1, jmp_target=8'h40 at the edge where ir_pc becomes 8'h10 → next edge ir_valid=0, ir=0; following edge ir=ROM[8'h40], ir_pc=8'h40, then 8'h41.
- Jump plus stall: jmp=1 and stall=1 on the same edge, target 8'h20 → same as the plain jump case; ir=ROM[8'h20] two edges later.
- HALT and reset: ROM[3]=16'hF000.
  - With FETCH_HALT_EN: ir=16'hF000, ir_valid=1 for one cycle, then halted=1, ir_valid=0, and a jmp pulse is ignored.
  - Without FETCH_HALT_EN: ROM[4] follows normally.
  - rst pulsed between edges → halted=0, ir_valid=0 immediately.
